// File: rtl/ip_vlg_pkg.sv
// ---------------------------------------------------------------------------
// ip_vlg_pkg
// Shared definitions for the IPv4 receive dispatcher:
//   - IPv4 protocol numbers and the limited-broadcast address
//   - rx_sel_t, the one-hot consumer select (bit0 ICMP, bit1 UDP, bit2+i TCP i),
//     sized for the largest supported TCP fan-out
//   - delay-line depth and packed delay-word width
//   - dispatcher FSM state encoding
// ---------------------------------------------------------------------------
package ip_vlg_pkg;

  localparam logic [7:0]  PROTO_ICMP = 8'd1;
  localparam logic [7:0]  PROTO_UDP  = 8'd17;
  localparam logic [7:0]  PROTO_TCP  = 8'd6;
  localparam logic [31:0] IPV4_BCAST = 32'hFFFF_FFFF;

  localparam int MAX_TCP   = 8;
  localparam int DLY_DEPTH = 4;
  // Delay word layout: {d[7:0], v, sof, eof, err}
  localparam int DLY_W     = 12;

  typedef logic [MAX_TCP+1:0] rx_sel_t;

  localparam rx_sel_t SEL_ICMP = rx_sel_t'(1);
  localparam rx_sel_t SEL_UDP  = rx_sel_t'(2);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_ROUTE   = 2'd2,
    ST_DROP    = 2'd3
  } rx_state_e;

endpackage

// File: rtl/rx_dly_line.sv
// ---------------------------------------------------------------------------
// rx_dly_line
// Fixed-depth shift register that free-runs every clock; gaps in the input
// stream therefore reappear unchanged at the output.
// Ports:
//   clk, rst     clock, asynchronous active-low reset (clears every stage)
//   i_din        word entering stage 1
//   i_s1_or      bits ORed into the stage-1 word as it moves to stage 2,
//                used to force flags onto the byte already in flight
//   o_last       last stage (the delayed word)
// ---------------------------------------------------------------------------
module rx_dly_line #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_din,
  input  logic [WIDTH-1:0] i_s1_or,
  output logic [WIDTH-1:0] o_last
);

  logic [WIDTH-1:0] r_stg [DEPTH];

  // Plain shift chain; the only twist is the OR mask applied between
  // stage 1 and stage 2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) r_stg[k] <= '0;
    end else begin
      r_stg[0] <= i_din;
      r_stg[1] <= r_stg[0] | i_s1_or;
      for (int k = 2; k < DEPTH; k++) r_stg[k] <= r_stg[k-1];
    end
  end

  assign o_last = r_stg[DEPTH-1];

endmodule

// File: rtl/ipv4_rx_dmux.sv
// ---------------------------------------------------------------------------
// ipv4_rx_dmux
// Classifies each received IPv4 payload (ICMP, UDP, or TCP by destination
// port) and forwards it, delayed by a fixed 4 cycles, to exactly one consumer.
// Unowned, short-TCP and aborted packets are counted in a saturating counter.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   dev_ipv4          local IPv4 address
//   tcp_port          N_TCP x 16-bit local ports, 0 = instance closed
//   in_d/v/sof/eof/err  payload byte stream from the IPv4 parser
//   in_proto, in_dst_ipv4  header fields, stable for the whole packet
//   out_d/sof/eof/err delayed stream shared by all consumers
//   out_v             one-hot valid: bit0 ICMP, bit1 UDP, bit2+i TCP i
//   drop_cnt          saturating dropped/aborted packet count
// ---------------------------------------------------------------------------
module ipv4_rx_dmux
  import ip_vlg_pkg::*;
#(
  parameter int N_TCP = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        dev_ipv4,
  input  logic [N_TCP*16-1:0] tcp_port,
  input  logic [7:0]         in_d,
  input  logic               in_v,
  input  logic               in_sof,
  input  logic               in_eof,
  input  logic               in_err,
  input  logic [7:0]         in_proto,
  input  logic [31:0]        in_dst_ipv4,
  output logic [7:0]         out_d,
  output logic [N_TCP+1:0]   out_v,
  output logic               out_sof,
  output logic               out_eof,
  output logic               out_err,
  output logic [15:0]        drop_cnt
);

  localparam int SW = N_TCP + 2;
  typedef logic [SW-1:0] sel_t;

  rx_state_e        r_state, w_state_nxt;
  logic [1:0]       r_idx;
  logic [7:0]       r_port_hi;
  // Decision queue: one slot per sof in flight through the delay line.
  // At most 4 packets can be between classification and the output.
  sel_t             r_q_sel [4];
  logic [3:0]       r_q_rdy;
  logic [1:0]       r_wp, r_rp, r_tcp_slot;
  logic             r_tcp_pend;
  sel_t             r_sel;
  logic [15:0]      r_drop;

  logic             w_push, w_push_rdy, w_resolve, w_abort, w_tcp_start;
  sel_t             w_push_sel, w_resolve_sel, w_match, w_head, w_sel_now;
  logic [1:0]       w_inc;
  logic             w_addr_ok, w_pop, w_pop_late;
  logic [15:0]      w_port;
  logic [16:0]      w_sum;
  logic [DLY_W-1:0] w_din, w_s1_or, w_last;

  assign w_addr_ok = (in_dst_ipv4 == dev_ipv4) || (in_dst_ipv4 == IPV4_BCAST);
  assign w_din     = {in_d, in_v, in_v & in_sof, in_v & in_eof, in_v & in_err};
  assign w_s1_or   = {{(DLY_W-2){1'b0}}, w_abort, w_abort};

  rx_dly_line #(.WIDTH(DLY_W), .DEPTH(DLY_DEPTH)) u_dly (
    .clk     (clk),
    .rst     (rst),
    .i_din   (w_din),
    .i_s1_or (w_s1_or),
    .o_last  (w_last)
  );

  // Port match: iterate high to low so the lowest matching instance wins.
  always_comb begin
    w_port  = {r_port_hi, in_d};
    w_match = '0;
    for (int i = N_TCP - 1; i >= 0; i--) begin
      if (tcp_port[i*16 +: 16] == w_port && tcp_port[i*16 +: 16] != 16'd0) begin
        w_match        = '0;
        w_match[i + 2] = 1'b1;
      end
    end
  end

  // Next-state and queue/counter controls. A sof always enqueues one
  // decision; TCP enqueues a pending entry that is completed at byte 3,
  // at a short eof, or when the packet is aborted.
  always_comb begin
    w_state_nxt   = r_state;
    w_push        = 1'b0;
    w_push_sel    = '0;
    w_push_rdy    = 1'b1;
    w_resolve     = 1'b0;
    w_resolve_sel = '0;
    w_abort       = 1'b0;
    w_tcp_start   = 1'b0;
    w_inc         = 2'd0;
    if (in_v && in_sof) begin
      w_push = 1'b1;
      if (r_state != ST_IDLE) begin
        w_abort = 1'b1;
        if (r_state == ST_COLLECT) w_resolve = 1'b1;
        if (r_state != ST_DROP)    w_inc = 2'd1;
      end
      if (!w_addr_ok) begin
        w_state_nxt = ST_DROP;
      end else begin
        case (in_proto)
          PROTO_ICMP: begin w_state_nxt = ST_ROUTE; w_push_sel = SEL_ICMP[SW-1:0]; end
          PROTO_UDP:  begin w_state_nxt = ST_ROUTE; w_push_sel = SEL_UDP[SW-1:0];  end
          PROTO_TCP:  begin w_state_nxt = ST_COLLECT; w_push_rdy = 1'b0; w_tcp_start = 1'b1; end
          default:    w_state_nxt = ST_DROP;
        endcase
      end
      if (w_state_nxt == ST_DROP) w_inc = w_inc + 2'd1;
      if (in_eof) begin
        // A one-byte TCP payload can never carry a port.
        if (w_tcp_start) begin
          w_tcp_start = 1'b0;
          w_push_rdy  = 1'b1;
          w_inc       = w_inc + 2'd1;
        end
        w_state_nxt = ST_IDLE;
      end
    end else if (in_v) begin
      case (r_state)
        ST_COLLECT: begin
          if (r_idx == 2'd3) begin
            w_resolve     = 1'b1;
            w_resolve_sel = w_match;
            w_state_nxt   = (w_match == '0) ? ST_DROP : ST_ROUTE;
            if (w_match == '0) w_inc = 2'd1;
            if (in_eof) w_state_nxt = ST_IDLE;
          end else if (in_eof) begin
            w_resolve   = 1'b1;
            w_inc       = 2'd1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_ROUTE, ST_DROP: if (in_eof) w_state_nxt = ST_IDLE;
        default: ;
      endcase
    end
  end

  // Output select: a delayed sof takes its decision from the queue head.
  // A TCP decision that is still unresolved at that point (header bytes
  // arrived with gaps) yields no consumer, and the late resolve is ignored.
  assign w_pop      = w_last[3] & w_last[2];
  assign w_head     = r_q_rdy[r_rp] ? r_q_sel[r_rp] : '0;
  assign w_pop_late = w_pop && !r_q_rdy[r_rp] && r_tcp_pend && (r_tcp_slot == r_rp);
  assign w_sel_now  = w_pop ? w_head : r_sel;
  assign w_sum      = {1'b0, r_drop} + {15'd0, w_inc};

  // State, header capture, decision queue, select and drop counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_idx      <= 2'd0;
      r_port_hi  <= 8'd0;
      for (int k = 0; k < 4; k++) r_q_sel[k] <= '0;
      r_q_rdy    <= 4'd0;
      r_wp       <= 2'd0;
      r_rp       <= 2'd0;
      r_tcp_slot <= 2'd0;
      r_tcp_pend <= 1'b0;
      r_sel      <= '0;
      r_drop     <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      if (in_v && in_sof)                 r_idx <= 2'd1;
      else if (in_v && r_idx != 2'd3)     r_idx <= r_idx + 2'd1;
      if (in_v && !in_sof && r_state == ST_COLLECT && r_idx == 2'd2) r_port_hi <= in_d;
      if (w_push) begin
        r_q_sel[r_wp] <= w_push_sel;
        r_q_rdy[r_wp] <= w_push_rdy;
        r_wp          <= r_wp + 2'd1;
      end
      if (w_resolve && r_tcp_pend) begin
        r_q_sel[r_tcp_slot] <= w_resolve_sel;
        r_q_rdy[r_tcp_slot] <= 1'b1;
      end
      if (w_tcp_start) begin
        r_tcp_slot <= r_wp;
        r_tcp_pend <= 1'b1;
      end else if (w_resolve || w_pop_late) begin
        r_tcp_pend <= 1'b0;
      end
      if (w_pop) r_rp <= r_rp + 2'd1;
      if (w_last[3] && w_last[1]) r_sel <= '0;
      else                        r_sel <= w_sel_now;
      r_drop <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
    end
  end

  assign out_d    = w_last[11:4];
  assign out_sof  = w_last[2];
  assign out_eof  = w_last[1];
  assign out_err  = w_last[0];
  assign out_v    = w_sel_now & {SW{w_last[3]}};
  assign drop_cnt = r_drop;

endmodule

// File: tb/tb_ipv4_rx_dmux.sv
// ---------------------------------------------------------------------------
// tb_ipv4_rx_dmux
// Directed bench for ipv4_rx_dmux with two TCP instances (ports 80, 1234).
// Every driven slot records the output word the bench expects 4 cycles later;
// a negedge monitor records what the design produced.
// ---------------------------------------------------------------------------
module tb_ipv4_rx_dmux;

  localparam logic [31:0] DEV   = 32'h0A00_0005;
  localparam logic [31:0] OTHER = 32'h0A00_0009;
  localparam logic [31:0] BCAST = 32'hFFFF_FFFF;

  logic        clk;
  logic        rst;
  logic [31:0] devIpv4;
  logic [31:0] tcpPort;
  logic [7:0]  inD;
  logic        inV, inSof, inEof, inErr;
  logic [7:0]  inProto;
  logic [31:0] inDst;
  logic [7:0]  outD;
  logic [3:0]  outV;
  logic        outSof, outEof, outErr;
  logic [15:0] dropCnt;

  int checks   = 0;
  int failures = 0;

  logic [14:0] expQ[$];
  logic [14:0] monQ[$];
  logic        monEn = 1'b0;
  logic        armed = 1'b0;

  ipv4_rx_dmux #(.N_TCP(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .dev_ipv4    (devIpv4),
    .tcp_port    (tcpPort),
    .in_d        (inD),
    .in_v        (inV),
    .in_sof      (inSof),
    .in_eof      (inEof),
    .in_err      (inErr),
    .in_proto    (inProto),
    .in_dst_ipv4 (inDst),
    .out_d       (outD),
    .out_v       (outV),
    .out_sof     (outSof),
    .out_eof     (outEof),
    .out_err     (outErr),
    .drop_cnt    (dropCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output capture, mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (monEn) monQ.push_back({outV, outD, outSof, outEof, outErr});
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of input and record the expected output word.
  task automatic applyStimulus(input logic v, input logic sof, input logic eof, input logic err,
                               input logic [7:0] d, input logic [7:0] proto,
                               input logic [31:0] dst, input logic [3:0] expV);
    @(posedge clk);
    #1;
    inV = v; inSof = sof; inEof = eof; inErr = err;
    inD = d; inProto = proto; inDst = dst;
    expQ.push_back({v ? expV : 4'h0, d, sof, eof, err});
    if (armed) begin
      monEn = 1'b1;
      armed = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, DEV, 4'h0);
  endtask

  task automatic startCapture();
    expQ.delete();
    monQ.delete();
    armed = 1'b1;
  endtask

  // Bytes 2..3 carry the port (meaningful for TCP). cut>0 stops after cut
  // bytes without eof; the last sent byte must then appear with eof/err set.
  task automatic sendPkt(input logic [7:0] proto, input logic [31:0] dst, input int len,
                         input logic [15:0] port, input logic [7:0] base, input logic [3:0] expV,
                         input int gapAfter, input int errIdx, input int cut);
    logic [7:0] d;
    for (int i = 0; i < len; i++) begin
      if (cut > 0 && i == cut) break;
      d = (i == 2) ? port[15:8] : (i == 3) ? port[7:0] : base + 8'(i);
      applyStimulus(1'b1, i == 0, i == len - 1, i == errIdx, d, proto, dst, expV);
      if (i == gapAfter && i != len - 1) idle(1);
    end
    if (cut > 0) expQ[expQ.size()-1] = expQ[expQ.size()-1] | 15'h3;
  endtask

  task automatic verifyRun(input string tag);
    logic [14:0] e, m;
    idle(6);
    @(negedge clk);
    #1;
    monEn = 1'b0;
    checkOutput({tag, " capture"}, 32'(monQ.size() >= expQ.size()), 32'd1);
    for (int s = 0; s + 4 < monQ.size() && s < expQ.size(); s++) begin
      e = expQ[s];
      m = monQ[s + 4];
      checkOutput($sformatf("%s v s%0d", tag, s), 32'(m[14:11]), 32'(e[14:11]));
      if (e[14:11] != 4'h0) begin
        checkOutput($sformatf("%s d s%0d", tag, s), 32'(m[10:3]), 32'(e[10:3]));
        checkOutput($sformatf("%s flags s%0d", tag, s), 32'(m[2:0]), 32'(e[2:0]));
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    devIpv4 = DEV;
    tcpPort = {16'd1234, 16'd80};
    inD = 8'h00; inV = 1'b0; inSof = 1'b0; inEof = 1'b0; inErr = 1'b0;
    inProto = 8'h00; inDst = DEV;
    #23;
    checkOutput("reset out_v", 32'(outV), 32'd0);
    checkOutput("reset out_d", 32'(outD), 32'd0);
    checkOutput("reset flags", 32'({outSof, outEof, outErr}), 32'd0);
    checkOutput("reset drop", 32'(dropCnt), 32'd0);
    rst = 1'b1;
    idle(2);

    // ICMP to local address, 8 bytes
    startCapture();
    sendPkt(8'd1, DEV, 8, 16'h0000, 8'h10, 4'b0001, -1, -1, 0);
    verifyRun("icmp");
    checkOutput("icmp drop", 32'(dropCnt), 32'd0);

    // TCP to port 1234 -> instance 1 (out_v bit3), 20 bytes
    startCapture();
    sendPkt(8'd6, DEV, 20, 16'd1234, 8'h40, 4'b1000, -1, -1, 0);
    verifyRun("tcp1234");
    checkOutput("tcp drop", 32'(dropCnt), 32'd0);

    // UDP to foreign address, then TCP to unowned port 22
    startCapture();
    sendPkt(8'd17, OTHER, 4, 16'h0000, 8'h60, 4'b0000, -1, -1, 0);
    sendPkt(8'd6, DEV, 8, 16'd22, 8'h70, 4'b0000, -1, -1, 0);
    verifyRun("unowned");
    checkOutput("unowned drop", 32'(dropCnt), 32'd2);

    // 3-byte TCP, UDP aborted after 3 bytes by an ICMP sof
    startCapture();
    sendPkt(8'd6, DEV, 3, 16'd80, 8'h80, 4'b0000, -1, -1, 0);
    sendPkt(8'd17, DEV, 6, 16'h0000, 8'h90, 4'b0010, -1, -1, 3);
    sendPkt(8'd1, BCAST, 5, 16'h0000, 8'hA0, 4'b0001, -1, -1, 0);
    verifyRun("abort");
    checkOutput("abort drop", 32'(dropCnt), 32'd4);

    // Back-to-back ICMP/UDP/TCP(80) with gaps, error on UDP byte 5
    startCapture();
    sendPkt(8'd1, DEV, 4, 16'h0000, 8'hB0, 4'b0001, 1, -1, 0);
    sendPkt(8'd17, DEV, 8, 16'h0000, 8'hC0, 4'b0010, 3, 5, 0);
    sendPkt(8'd6, DEV, 6, 16'd80, 8'hD0, 4'b0100, 4, -1, 0);
    verifyRun("b2b");
    checkOutput("b2b drop", 32'(dropCnt), 32'd4);

    // Saturation: 65540 one-byte packets with an unknown protocol
    for (int n = 0; n < 65530; n++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'd99, DEV, 4'h0);
    idle(1);
    checkOutput("sat fffe", 32'(dropCnt), 32'hFFFE);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'd99, DEV, 4'h0);
    idle(1);
    checkOutput("sat ffff", 32'(dropCnt), 32'hFFFF);
    for (int n = 0; n < 9; n++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'd99, DEV, 4'h0);
    idle(1);
    checkOutput("sat hold", 32'(dropCnt), 32'hFFFF);
    expQ.delete();

    // Async reset in the middle of a routed ICMP packet
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b1, i == 0, 1'b0, 1'b0, 8'hE0 + 8'(i), 8'd1, DEV, 4'b0001);
    checkOutput("pre-reset out_v", 32'(outV), 32'd1);
    checkOutput("pre-reset out_d", 32'(outD), 32'hE1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async out_v", 32'(outV), 32'd0);
    checkOutput("async out_d", 32'(outD), 32'd0);
    checkOutput("async flags", 32'({outSof, outEof, outErr}), 32'd0);
    checkOutput("async drop", 32'(dropCnt), 32'd0);
    inV = 1'b0; inSof = 1'b0; inEof = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(1);
    startCapture();
    sendPkt(8'd17, BCAST, 5, 16'h0000, 8'hF0, 4'b0010, -1, -1, 0);
    verifyRun("post-reset");
    checkOutput("post-reset drop", 32'(dropCnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
